// File: rtl/digit_bbox_if.sv
// Pixel-stream in / committed-box out bundle for digit_bbox.
// The master drives the binarised pixel stream; the slave (digit_bbox) returns the committed box.
interface digit_bbox_if;
  logic        pix_valid;
  logic [8:0]  hcnt;
  logic [8:0]  vcnt;
  logic        binary_i;
  logic [8:0]  x_min;
  logic [8:0]  x_max;
  logic [8:0]  y_min;
  logic [8:0]  y_max;
  logic [16:0] pix_count;
  logic        bbox_valid;
  logic        frame_done;

  modport master (
    output pix_valid, hcnt, vcnt, binary_i,
    input  x_min, x_max, y_min, y_max, pix_count, bbox_valid, frame_done
  );

  modport slave (
    input  pix_valid, hcnt, vcnt, binary_i,
    output x_min, x_max, y_min, y_max, pix_count, bbox_valid, frame_done
  );
endinterface

// File: rtl/digit_bbox.sv
// Per-frame bounding box and foreground count of the binarised pixel stream.
// Results are committed at frame end and held stable for the whole following frame.
module digit_bbox #(
  parameter int unsigned H_ACT    = 320,
  parameter int unsigned V_ACT    = 240,
  parameter int unsigned MIN_PIX  = 16,
  parameter logic        FG_LEVEL = 1'b0
) (
  input logic         pclk,
  input logic         iRST_N,
  digit_bbox_if.slave bus
);

  typedef enum logic [1:0] {StIdle, StAccum, StCommit} state_e;
  state_e state_q, state_d;

  logic       valid_q;
  logic [8:0] h_q, v_q;
  logic       bin_q;

  always_ff @(posedge pclk or negedge iRST_N) begin
    if (!iRST_N) begin
      valid_q <= 1'b0;
      h_q     <= '0;
      v_q     <= '0;
      bin_q   <= 1'b0;
    end else begin
      valid_q <= bus.pix_valid;
      h_q     <= bus.hcnt;
      v_q     <= bus.vcnt;
      bin_q   <= bus.binary_i;
    end
  end

  logic in_range, is_start, is_last, is_fg, process;
  assign in_range = valid_q && (32'(h_q) < H_ACT) && (32'(v_q) < V_ACT);
  assign is_start = in_range && (h_q == '0) && (v_q == '0);
  assign is_last  = in_range && (h_q == 9'(H_ACT - 1)) && (v_q == 9'(V_ACT - 1));
  assign is_fg    = in_range && (bin_q == FG_LEVEL);
  // A frame start is taken in any state; a restart in StAccum discards the partial frame.
  assign process  = is_start || ((state_q == StAccum) && in_range);

  always_ff @(posedge pclk or negedge iRST_N) begin
    if (!iRST_N) state_q <= StIdle;
    else         state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      StIdle, StCommit: begin
        if (is_start) state_d = is_last ? StCommit : StAccum;
        else          state_d = StIdle;
      end
      StAccum: begin
        if (is_last) state_d = StCommit;
      end
      default: state_d = StIdle;
    endcase
  end

  always_comb begin
    bus.frame_done = (state_q == StCommit);
  end

  logic [8:0]  xmin_q, xmax_q, ymin_q, ymax_q;
  logic [8:0]  xmin_d, xmax_d, ymin_d, ymax_d;
  logic [16:0] cnt_q, cnt_d;
  logic        seen_q, seen_d;

  always_comb begin
    xmin_d = is_start ? '0 : xmin_q;
    xmax_d = is_start ? '0 : xmax_q;
    ymin_d = is_start ? '0 : ymin_q;
    ymax_d = is_start ? '0 : ymax_q;
    cnt_d  = is_start ? '0 : cnt_q;
    seen_d = is_start ? 1'b0 : seen_q;
    if (process && is_fg) begin
      if (!seen_d) begin
        xmin_d = h_q;
        xmax_d = h_q;
        ymin_d = v_q;
        ymax_d = v_q;
      end else begin
        if (h_q < xmin_d) xmin_d = h_q;
        if (h_q > xmax_d) xmax_d = h_q;
        if (v_q < ymin_d) ymin_d = v_q;
        if (v_q > ymax_d) ymax_d = v_q;
      end
      cnt_d  = cnt_d + 17'd1;
      seen_d = 1'b1;
    end
  end

  always_ff @(posedge pclk or negedge iRST_N) begin
    if (!iRST_N) begin
      xmin_q <= '0;
      xmax_q <= '0;
      ymin_q <= '0;
      ymax_q <= '0;
      cnt_q  <= '0;
      seen_q <= 1'b0;
    end else begin
      xmin_q <= xmin_d;
      xmax_q <= xmax_d;
      ymin_q <= ymin_d;
      ymax_q <= ymax_d;
      cnt_q  <= cnt_d;
      seen_q <= seen_d;
    end
  end

  logic [8:0]  out_xmin_q, out_xmax_q, out_ymin_q, out_ymax_q;
  logic [16:0] out_cnt_q;
  logic        out_valid_q;

  // Loaded on the edge entering StCommit so the new box is visible alongside frame_done.
  always_ff @(posedge pclk or negedge iRST_N) begin
    if (!iRST_N) begin
      out_xmin_q  <= '0;
      out_xmax_q  <= '0;
      out_ymin_q  <= '0;
      out_ymax_q  <= '0;
      out_cnt_q   <= '0;
      out_valid_q <= 1'b0;
    end else if (state_d == StCommit) begin
      out_cnt_q <= cnt_d;
      if (32'(cnt_d) >= MIN_PIX) begin
        out_xmin_q  <= xmin_d;
        out_xmax_q  <= xmax_d;
        out_ymin_q  <= ymin_d;
        out_ymax_q  <= ymax_d;
        out_valid_q <= 1'b1;
      end else begin
        out_valid_q <= 1'b0;
      end
    end
  end

  assign bus.x_min      = out_xmin_q;
  assign bus.x_max      = out_xmax_q;
  assign bus.y_min      = out_ymin_q;
  assign bus.y_max      = out_ymax_q;
  assign bus.pix_count  = out_cnt_q;
  assign bus.bbox_valid = out_valid_q;

endmodule

// File: doc/digit_bbox.md
# digit_bbox

Per-frame bounding-box extractor for the binarised camera stream. It sits downstream of the threshold/binarisation stage and next to `image_process`, in the `clk25` (pixel) domain. It scans each 320x240 window, tracks the extent and count of foreground (digit) pixels, and publishes a stable box at every frame end. The recogniser and the VGA overlay use that box to locate the digit.

## Interface
Parameters:
- `H_ACT`, 320, active pixels per line
- `V_ACT`, 240, active lines per frame
- `MIN_PIX`, 16, minimum foreground count for a valid box
- `FG_LEVEL`, 1'b0, `binary_i` value treated as foreground (dark ink)

Ports:
- `pclk` in 1: pixel clock, `clk25`
- `iRST_N` in 1: asynchronous active-low reset
- `pix_valid` in 1: current `hcnt`/`vcnt`/`binary_i` is an active-window pixel
- `hcnt` in 9: column, 0..H_ACT-1
- `vcnt` in 9: row, 0..V_ACT-1
- `binary_i` in 1: binarised pixel
- `x_min`, `x_max` out 9: committed horizontal extent
- `y_min`, `y_max` out 9: committed vertical extent
- `pix_count` out 17: committed foreground count, max 76800
- `bbox_valid` out 1: committed box has `pix_count >= MIN_PIX`
- `frame_done` out 1: one-cycle pulse when the committed outputs update

## Operation
- Stage 1 registers `pix_valid`, `hcnt`, `vcnt` and `binary_i` on every `pclk`.
- Stage 2 is the FSM plus accumulators. The FSM states are:
  - IDLE: wait for a stage-1 pixel with `pix_valid=1`, `hcnt=0`, `vcnt=0`. On that pixel, clear the accumulators, process the pixel, and go to ACCUM.
  - ACCUM: process every valid pixel. On the pixel with `hcnt=H_ACT-1` and `vcnt=V_ACT-1`, process it and go to COMMIT.
  - COMMIT: lasts exactly one cycle. Transfer the results, pulse `frame_done`, then go to ACCUM-armed IDLE (back to IDLE).
- Processing a pixel: a valid pixel with `binary_i==FG_LEVEL` is foreground.
  - The first foreground pixel of a frame loads `acc_xmin=acc_xmax=hcnt` and `acc_ymin=acc_ymax=vcnt`. A local `seen` flag marks that this has happened.
  - Each later foreground pixel updates min/max with unsigned compares.
  - The count increments by 1 and never exceeds 76800. No saturation logic is required; the 17-bit width is sufficient.
- Pixels with `hcnt>=H_ACT` or `vcnt>=V_ACT` are ignored even if `pix_valid=1`. They never terminate the frame.
- A gap in `pix_valid` (blanking or stalls) pauses accumulation. Accumulator state is held.
- Frame restart: if the `hcnt=0,vcnt=0` valid pixel arrives while in ACCUM, the partial frame is discarded. No `frame_done` is issued. The accumulators restart with that pixel included.
- Commit:
  - `pix_count` always takes the accumulator value.
  - If count `>= MIN_PIX`: the box outputs take the accumulators and `bbox_valid=1`.
  - Otherwise the box outputs hold their previous values and `bbox_valid=0`.
  - An empty frame (count 0) commits `pix_count=0` and `bbox_valid=0`.
- Committed outputs change only in the COMMIT cycle. They are stable for the whole following frame.
- Invariant when `bbox_valid=1`: `x_min<=x_max` and `y_min<=y_max`.

## Timing
- Reset (`iRST_N=0`, asynchronous assert):
  - All outputs are 0: `x_min`, `x_max`, `y_min`, `y_max`, `pix_count`, `bbox_valid`, `frame_done`.
  - The FSM is in IDLE, the accumulators are 0, and `seen=0`.
  - Deassertion is synchronised externally. The first frame counted is the first full frame start seen after release.
- Reset during ACCUM drops the frame. No `frame_done` is issued.
- Latency: the last pixel is presented at the inputs in cycle N. It is registered at N+1 and accumulated in N+1 (ACCUM leaves at the N+1 edge). Outputs update and `frame_done=1` in cycle N+2. `frame_done` is low in N+3.
- The last pixel being foreground is included in the committed result.
- Back-to-back frames: a new frame start may arrive at input cycle N+1 or later. COMMIT accepts a frame-start pixel in the same cycle and enters ACCUM with it processed, so no pixel is lost.
- Throughput: one pixel per `pclk`, no backpressure.

## Test plan
- Square digit: foreground for columns 100..139, rows 60..109 of a full frame -> one `frame_done`, 2 cycles after the last pixel. Outputs: `x_min=100`, `x_max=139`, `y_min=60`, `y_max=109`, `pix_count=2000`, `bbox_valid=1`.
- Sparse frame, then blank frame: first frame has 5 foreground pixels spanning (10,10)..(20,30); second frame is all background.
  - After frame 1: `pix_count=5`, `bbox_valid=0`, box = reset values (0,0,0,0).
  - After frame 2: `pix_count=0`, `bbox_valid=0`, box unchanged.
- Corner pixels: foreground only at (0,0) and (319,239), `MIN_PIX=2` -> box 0..319 x 0..239, `pix_count=2`, `bbox_valid=1`. The last pixel is counted.
- Restart: frame start, then foreground at (50,50), then a new frame start at row 100, then a full frame with only (200,200) foreground and `MIN_PIX=1` -> a single `frame_done` with box (200,200,200,200) and `pix_count=1`.
- Stalls and out-of-range: the square-digit frame with random `pix_valid` gaps, plus injected `hcnt=400` foreground pixels -> results identical to the square-digit scenario.
- Async reset mid-frame: assert `iRST_N=0` at row 120 -> all outputs 0 immediately. No `frame_done` for that frame. The next full frame commits correctly.
